// File: rtl/ram_2w2r_port_arbiter.sv
// Shares the two read and two write ports of a 2W2R RAM among NUM_REQ requesters using
// independent dual-grant round-robin arbiters, and routes 1-cycle read returns to their owners.
module ram_2w2r_port_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned REQ_IDX_WIDTH  = 2,
    parameter int unsigned RAM_ADDR_WIDTH = 8,
    parameter int unsigned RAM_DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                rd_req_val_i,
    input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0] rd_req_addr_i,
    output logic [NUM_REQ-1:0]                rd_req_rdy_o,
    output logic [NUM_REQ-1:0]                rd_rsp_val_o,
    output logic [NUM_REQ-1:0]                rd_rsp_sel_o,
    output logic [RAM_DATA_WIDTH-1:0]         rd_rsp_data_o,
    output logic [RAM_DATA_WIDTH-1:0]         rd_rsp_data1_o,
    input  logic [NUM_REQ-1:0]                wr_req_val_i,
    input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0] wr_req_addr_i,
    input  logic [NUM_REQ*RAM_DATA_WIDTH-1:0] wr_req_data_i,
    output logic [NUM_REQ-1:0]                wr_req_rdy_o,
    output logic                              r0_val_o,
    output logic [RAM_ADDR_WIDTH-1:0]         r0_addr_o,
    input  logic [RAM_DATA_WIDTH-1:0]         r0_data_i,
    output logic                              r1_val_o,
    output logic [RAM_ADDR_WIDTH-1:0]         r1_addr_o,
    input  logic [RAM_DATA_WIDTH-1:0]         r1_data_i,
    output logic                              w0_val_o,
    output logic [RAM_ADDR_WIDTH-1:0]         w0_addr_o,
    output logic [RAM_DATA_WIDTH-1:0]         w0_data_o,
    output logic                              w1_val_o,
    output logic [RAM_ADDR_WIDTH-1:0]         w1_addr_o,
    output logic [RAM_DATA_WIDTH-1:0]         w1_data_o,
    output logic [CNT_WIDTH-1:0]              wr_conflict_cnt_o
);

    localparam int unsigned AW = RAM_ADDR_WIDTH;
    localparam int unsigned DW = RAM_DATA_WIDTH;
    localparam int unsigned IW = REQ_IDX_WIDTH;

    function automatic logic [IW-1:0] wrap_add(logic [IW-1:0] base, int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IW'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(logic vld, logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = vld;
        return oh;
    endfunction

    function automatic logic [AW-1:0] addr_of(logic [NUM_REQ*AW-1:0] vec, logic [IW-1:0] idx);
        return vec[32'(idx)*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(logic [NUM_REQ*DW-1:0] vec, logic [IW-1:0] idx);
        return vec[32'(idx)*DW +: DW];
    endfunction

    // Gating with rst_n keeps every grant and RAM valid low for the whole reset window.
    logic [NUM_REQ-1:0] rd_val, wr_val;
    assign rd_val = rd_req_val_i & {NUM_REQ{rst_n}};
    assign wr_val = wr_req_val_i & {NUM_REQ{rst_n}};

    logic [IW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic                 rd_g0_vld, rd_g1_vld, wr_g0_vld, wr_g1_vld, wr_conflict;
    logic [IW-1:0]        rd_g0_idx, rd_g1_idx, wr_g0_idx, wr_g1_idx;
    logic                 rsp_vld0_q, rsp_vld1_q;
    logic [IW-1:0]        rsp_own0_q, rsp_own1_q;
    logic [NUM_REQ-1:0]   rsp_sel_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        rd_g0_vld = 1'b0;
        rd_g0_idx = '0;
        rd_g1_vld = 1'b0;
        rd_g1_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!rd_g0_vld && rd_val[wrap_add(rd_ptr_q, k)]) begin
                rd_g0_vld = 1'b1;
                rd_g0_idx = wrap_add(rd_ptr_q, k);
            end
        end
        for (int unsigned k = 1; k < NUM_REQ; k++) begin
            if (rd_g0_vld && !rd_g1_vld && rd_val[wrap_add(rd_g0_idx, k)]) begin
                rd_g1_vld = 1'b1;
                rd_g1_idx = wrap_add(rd_g0_idx, k);
            end
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_g1_vld) begin
            rd_ptr_d = wrap_add(rd_g1_idx, 1);
        end else if (rd_g0_vld) begin
            rd_ptr_d = wrap_add(rd_g0_idx, 1);
        end
    end

    // Second write slot skips anyone targeting G0's address; the skip is what gets counted.
    always_comb begin
        wr_g0_vld   = 1'b0;
        wr_g0_idx   = '0;
        wr_g1_vld   = 1'b0;
        wr_g1_idx   = '0;
        wr_conflict = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!wr_g0_vld && wr_val[wrap_add(wr_ptr_q, k)]) begin
                wr_g0_vld = 1'b1;
                wr_g0_idx = wrap_add(wr_ptr_q, k);
            end
        end
        for (int unsigned k = 1; k < NUM_REQ; k++) begin
            if (wr_g0_vld && !wr_g1_vld && wr_val[wrap_add(wr_g0_idx, k)]) begin
                if (addr_of(wr_req_addr_i, wrap_add(wr_g0_idx, k)) ==
                    addr_of(wr_req_addr_i, wr_g0_idx)) begin
                    wr_conflict = 1'b1;
                end else begin
                    wr_g1_vld = 1'b1;
                    wr_g1_idx = wrap_add(wr_g0_idx, k);
                end
            end
        end
        wr_ptr_d = wr_ptr_q;
        if (wr_g1_vld) begin
            wr_ptr_d = wrap_add(wr_g1_idx, 1);
        end else if (wr_g0_vld) begin
            wr_ptr_d = wrap_add(wr_g0_idx, 1);
        end
        cnt_d = cnt_q;
        if (wr_conflict && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rsp_vld0_q <= 1'b0;
            rsp_vld1_q <= 1'b0;
            rsp_own0_q <= '0;
            rsp_own1_q <= '0;
            rsp_sel_q  <= '0;
            cnt_q      <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rsp_vld0_q <= rd_g0_vld;
            rsp_vld1_q <= rd_g1_vld;
            rsp_own0_q <= rd_g0_idx;
            rsp_own1_q <= rd_g1_idx;
            rsp_sel_q  <= onehot(rd_g1_vld, rd_g1_idx);
            cnt_q      <= cnt_d;
        end
    end

    assign rd_req_rdy_o = onehot(rd_g0_vld, rd_g0_idx) | onehot(rd_g1_vld, rd_g1_idx);
    assign wr_req_rdy_o = onehot(wr_g0_vld, wr_g0_idx) | onehot(wr_g1_vld, wr_g1_idx);

    assign r0_val_o  = rd_g0_vld;
    assign r0_addr_o = rd_g0_vld ? addr_of(rd_req_addr_i, rd_g0_idx) : '0;
    assign r1_val_o  = rd_g1_vld;
    assign r1_addr_o = rd_g1_vld ? addr_of(rd_req_addr_i, rd_g1_idx) : '0;

    assign w0_val_o  = wr_g0_vld;
    assign w0_addr_o = wr_g0_vld ? addr_of(wr_req_addr_i, wr_g0_idx) : '0;
    assign w0_data_o = wr_g0_vld ? data_of(wr_req_data_i, wr_g0_idx) : '0;
    assign w1_val_o  = wr_g1_vld;
    assign w1_addr_o = wr_g1_vld ? addr_of(wr_req_addr_i, wr_g1_idx) : '0;
    assign w1_data_o = wr_g1_vld ? data_of(wr_req_data_i, wr_g1_idx) : '0;

    // Requesters with rd_rsp_sel set take rd_rsp_data1 (the r1 return).
    assign rd_rsp_val_o   = onehot(rsp_vld0_q, rsp_own0_q) | onehot(rsp_vld1_q, rsp_own1_q);
    assign rd_rsp_sel_o   = rsp_sel_q;
    assign rd_rsp_data_o  = r0_data_i;
    assign rd_rsp_data1_o = r1_data_i;

    assign wr_conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_ram_2w2r_port_arbiter.sv
// Directed bench for ram_2w2r_port_arbiter with a behavioural 2W2R RAM (write-first on
// same-address read/write) and hand-computed expectations.
module tb_ram_2w2r_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rd_val, rd_rdy, rsp_val, rsp_sel;
    logic [31:0] rd_addr;
    logic [31:0] rsp_data, rsp_data1;
    logic [3:0]  wr_val, wr_rdy;
    logic [31:0] wr_addr;
    logic [127:0] wr_data;
    logic        r0_val, r1_val, w0_val, w1_val;
    logic [7:0]  r0_addr, r1_addr, w0_addr, w1_addr;
    logic [31:0] r0_data, r1_data, w0_data, w1_data;
    logic [15:0] cnt;

    logic        mem_clr;
    logic [31:0] mem [0:255];

    int n_checks;
    int n_errors;
    int gnt_cnt [4];

    ram_2w2r_port_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rd_req_val_i      (rd_val),
        .rd_req_addr_i     (rd_addr),
        .rd_req_rdy_o      (rd_rdy),
        .rd_rsp_val_o      (rsp_val),
        .rd_rsp_sel_o      (rsp_sel),
        .rd_rsp_data_o     (rsp_data),
        .rd_rsp_data1_o    (rsp_data1),
        .wr_req_val_i      (wr_val),
        .wr_req_addr_i     (wr_addr),
        .wr_req_data_i     (wr_data),
        .wr_req_rdy_o      (wr_rdy),
        .r0_val_o          (r0_val),
        .r0_addr_o         (r0_addr),
        .r0_data_i         (r0_data),
        .r1_val_o          (r1_val),
        .r1_addr_o         (r1_addr),
        .r1_data_i         (r1_data),
        .w0_val_o          (w0_val),
        .w0_addr_o         (w0_addr),
        .w0_data_o         (w0_data),
        .w1_val_o          (w1_val),
        .w1_addr_o         (w1_addr),
        .w1_data_o         (w1_data),
        .wr_conflict_cnt_o (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ram_rd(logic [7:0] a);
        if (w1_val && w1_addr == a) return w1_data;
        if (w0_val && w0_addr == a) return w0_data;
        return mem[a];
    endfunction

    // Background content is 0xD00000aa so untouched reads are predictable.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hD000_0000 | 32'(i);
        end else begin
            r0_data <= ram_rd(r0_addr);
            r1_data <= ram_rd(r1_addr);
            if (w0_val) mem[w0_addr] <= w0_data;
            if (w1_val) mem[w1_addr] <= w1_data;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4; i++) gnt_cnt[i] = 0;
        mem_clr = 1'b1;
        rst_n   = 1'b0;
        rd_addr = 32'h1312_1110;
        wr_addr = 32'h5352_5150;
        wr_data = '0;
        rd_val  = 4'hF;
        wr_val  = 4'hF;

        // Reset: everything quiet despite requests pending
        #3;
        check_eq("rst_rd_rdy", rd_rdy, 4'h0);
        check_eq("rst_wr_rdy", wr_rdy, 4'h0);
        check_eq("rst_ram_val", {r0_val, r1_val, w0_val, w1_val}, 4'h0);
        check_eq("rst_rsp_val", rsp_val, 4'h0);
        check_eq("rst_rsp_sel", rsp_sel, 4'h0);
        check_eq("rst_cnt", cnt, 16'h0);
        step();
        step();
        mem_clr = 1'b0;
        rd_val  = 4'h0;
        wr_val  = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reads from four requesters take two cycles
        rd_val = 4'hF;
        #1;
        check_eq("rd_c0_rdy", rd_rdy, 4'b0011);
        check_eq("rd_c0_addr", {r0_val, r0_addr, r1_val, r1_addr}, {1'b1, 8'h10, 1'b1, 8'h11});
        step();
        rd_val = 4'b1100;
        #1;
        check_eq("rd_c1_rdy", rd_rdy, 4'b1100);
        check_eq("rd_rsp0_val", rsp_val, 4'b0011);
        check_eq("rd_rsp0_sel", rsp_sel, 4'b0010);
        check_eq("rd_rsp0_data", {rsp_data, rsp_data1}, {32'hD000_0010, 32'hD000_0011});
        step();
        rd_val = 4'h0;
        #1;
        check_eq("rd_rsp1_val", rsp_val, 4'b1100);
        check_eq("rd_rsp1_sel", rsp_sel, 4'b1000);
        check_eq("rd_rsp1_data", {rsp_data, rsp_data1}, {32'hD000_0012, 32'hD000_0013});
        step();
        check_eq("rd_rsp_idle", rsp_val, 4'h0);

        // Fairness: all reading continuously for 8 cycles
        rd_val = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            check_eq("fair_rdy", rd_rdy, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int i = 0; i < 4; i++) if (rd_rdy[i]) gnt_cnt[i]++;
            step();
        end
        rd_val = 4'h0;
        for (int i = 0; i < 4; i++) check_eq("fair_cnt", 64'(gnt_cnt[i]), 64'd4);
        step();

        // Write conflict: req0 and req1 both target 0x20
        wr_addr = 32'h0021_2020;
        wr_data = {32'h0, 32'hC, 32'hB, 32'hA};
        wr_val  = 4'b0111;
        #1;
        check_eq("wc_c0_rdy", wr_rdy, 4'b0101);
        check_eq("wc_c0_w0", {w0_val, w0_addr, w0_data}, {1'b1, 8'h20, 32'hA});
        check_eq("wc_c0_w1", {w1_val, w1_addr, w1_data}, {1'b1, 8'h21, 32'hC});
        step();
        wr_val = 4'b0010;
        #1;
        check_eq("wc_cnt1", cnt, 16'd1);
        check_eq("wc_c1_rdy", wr_rdy, 4'b0010);
        check_eq("wc_c1_w0", {w0_val, w0_addr, w0_data}, {1'b1, 8'h20, 32'hB});
        check_eq("wc_c1_w1_idle", {w1_val, w1_addr, w1_data}, 41'h0);
        step();
        wr_val = 4'h0;
        #1;
        check_eq("wc_cnt_hold", cnt, 16'd1);
        rd_addr = 32'h1312_1120;
        rd_val  = 4'b0001;
        #1;
        check_eq("wc_rb_rdy", rd_rdy, 4'b0001);
        step();
        rd_val = 4'h0;
        #1;
        check_eq("wc_rb_val", rsp_val, 4'b0001);
        check_eq("wc_rb_data", rsp_data, 32'hB);

        // Same-cycle write and read of 0x30: read returns the new data
        wr_addr = 32'h0000_0030;
        wr_data = {96'h0, 32'h55};
        wr_val  = 4'b0001;
        rd_addr = 32'h1312_3020;
        rd_val  = 4'b0010;
        #1;
        check_eq("raw_rd_rdy", rd_rdy, 4'b0010);
        check_eq("raw_wr_rdy", wr_rdy, 4'b0001);
        step();
        wr_val = 4'h0;
        rd_val = 4'h0;
        #1;
        check_eq("raw_rsp_val", rsp_val, 4'b0010);
        check_eq("raw_rsp_sel", rsp_sel, 4'b0000);
        check_eq("raw_rsp_data", rsp_data, 32'h55);

        // Reset with a read in flight
        rd_addr = 32'h1305_1110;
        rd_val  = 4'b0100;
        #1;
        check_eq("rif_rdy", rd_rdy, 4'b0100);
        step();
        rd_val = 4'h0;
        #1;
        check_eq("rif_rsp_pre", rsp_val, 4'b0100);
        @(negedge clk);
        rst_n  = 1'b0;
        rd_val = 4'b1000;
        wr_val = 4'hF;
        wr_addr = 32'h5352_5150;
        #1;
        check_eq("rif_rsp_drop", rsp_val, 4'h0);
        check_eq("rif_rdy_rst", {rd_rdy, wr_rdy}, 8'h0);
        check_eq("rif_ram_val", {r0_val, r1_val, w0_val, w1_val}, 4'h0);
        check_eq("rif_cnt", cnt, 16'd0);
        step();
        check_eq("rif_rsp_rst", rsp_val, 4'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        rd_addr = 32'h1312_1110;
        rd_val  = 4'hF;
        #1;
        check_eq("rif_resume_rd", rd_rdy, 4'b0011);
        check_eq("rif_resume_wr", wr_rdy, 4'b0011);
        step();
        rd_val = 4'h0;
        wr_val = 4'h0;
        #1;
        check_eq("rif_resume_rsp", rsp_val, 4'b0011);
        check_eq("rif_resume_data", {rsp_data, rsp_data1}, {32'hD000_0010, 32'hD000_0011});

        // Saturation: two writers to one address every cycle
        wr_addr = 32'h0000_4040;
        wr_data = {64'h0, 32'h2, 32'h1};
        wr_val  = 4'b0011;
        #1;
        check_eq("sat_rdy", wr_rdy, 4'b0001);
        check_eq("sat_w1", w1_val, 1'b0);
        for (int i = 1; i <= 65539; i++) begin
            step();
            if (i == 5) check_eq("sat_cnt5", cnt, 16'd5);
        end
        check_eq("sat_cnt_max", cnt, 16'hFFFF);
        step();
        check_eq("sat_cnt_hold", cnt, 16'hFFFF);
        wr_val = 4'h0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
